// File: rtl/traffic_sensor_cond.sv
// traffic_sensor_cond: per-street loop sync/debounce, vehicle queue, departure and hold timers driving TA/TB.
// Optional stuck-loop detection is built when SENSOR_STUCK_DETECT_EN is defined.
module traffic_sensor_cond #(
    parameter int DEB_CYCLES    = 4,
    parameter int DEPART_CYCLES = 8,
    parameter int HOLD_CYCLES   = 16,
    parameter int CNT_W         = 4,
    parameter int STUCK_CYCLES  = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       raw_a,
    input  logic       raw_b,
    input  logic [1:0] la,
    input  logic [1:0] lb,
    output logic       TA,
    output logic       TB,
    output logic       fault_a,
    output logic       fault_b
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int PW = $clog2(DEPART_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 2);
    localparam logic [CNT_W-1:0] QMAX = '1;

    logic [1:0] green, s1_q, s2_q, db_q, db_d, t_q, t_d, fault_q, flip, arr, dep;
    logic [1:0][DW-1:0]    deb_q, deb_d;
    logic [1:0][PW-1:0]    dep_q, dep_d;
    logic [1:0][HW-1:0]    hold_q, hold_d;
    logic [1:0][CNT_W-1:0] q_q, q_d;

    assign green = {lb == 2'b00, la == 2'b00};

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            flip[c]   = s2_q[c] != db_q[c] && deb_q[c] == DW'(DEB_CYCLES - 1);
            deb_d[c]  = (s2_q[c] == db_q[c] || flip[c]) ? '0 : deb_q[c] + 1'b1;
            db_d[c]   = db_q[c] ^ flip[c];
            arr[c]    = flip[c] & ~db_q[c];
            dep[c]    = green[c] && q_q[c] != '0 && dep_q[c] == PW'(DEPART_CYCLES - 1);
            dep_d[c]  = (!green[c] || q_q[c] == '0 || dep[c]) ? '0 : dep_q[c] + 1'b1;
            // simultaneous arrival and departure cancel out
            q_d[c]    = (arr[c] && !dep[c]) ? ((q_q[c] == QMAX) ? q_q[c] : q_q[c] + 1'b1) :
                        (dep[c] && !arr[c]) ? q_q[c] - 1'b1 : q_q[c];
            hold_d[c] = arr[c] ? HW'(HOLD_CYCLES) : (hold_q[c] != '0) ? hold_q[c] - 1'b1 : hold_q[c];
            t_d[c]    = db_q[c] | (q_q[c] != '0) | (hold_q[c] != '0) | fault_q[c];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= '0;
            s2_q   <= '0;
            db_q   <= '0;
            t_q    <= '0;
            deb_q  <= '0;
            dep_q  <= '0;
            hold_q <= '0;
            q_q    <= '0;
        end else begin
            s1_q   <= {raw_b, raw_a};
            s2_q   <= s1_q;
            db_q   <= db_d;
            t_q    <= t_d;
            deb_q  <= deb_d;
            dep_q  <= dep_d;
            hold_q <= hold_d;
            q_q    <= q_d;
        end
    end

`ifdef SENSOR_STUCK_DETECT_EN
    localparam int SW = $clog2(STUCK_CYCLES + 1);
    logic [1:0][SW-1:0] stk_q;

    // a fault is sticky and forces the request high so the street keeps being served
    always_ff @(posedge clk) begin
        if (rst) begin
            stk_q   <= '0;
            fault_q <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                stk_q[c]   <= !db_q[c] ? '0 : fault_q[c] ? stk_q[c] : stk_q[c] + 1'b1;
                fault_q[c] <= fault_q[c] | (db_q[c] && stk_q[c] == SW'(STUCK_CYCLES - 1));
            end
        end
    end
`else
    assign fault_q = 2'b00;
`endif

    assign TA      = t_q[0];
    assign TB      = t_q[1];
    assign fault_a = fault_q[0];
    assign fault_b = fault_q[1];
endmodule

// File: doc/traffic_sensor_cond.md
# traffic_sensor_cond

Conditions the raw vehicle-loop detector inputs of both streets into the clean `TA`/`TB` "traffic present" requests consumed by the traffic-light controller FSM. It sits directly upstream of the controller and also taps the controller's light outputs, `la`/`lb`, to model vehicles leaving on green. Each street gets:
- a synchroniser and debouncer;
- a saturating vehicle queue counter;
- a departure timer;
- a post-arrival hold timer.

The controller therefore sees a stable request while any vehicle is waiting.

## Interface
- `DEB_CYCLES`, 4: consecutive stable synchronised samples needed to change the debounced level (≥1).
- `DEPART_CYCLES`, 8: green cycles per departed vehicle (≥1).
- `HOLD_CYCLES`, 16: cycles `T` stays asserted after the last arrival (≥0).
- `CNT_W`, 4: queue counter width; saturates at 2^CNT_W−1.
- `STUCK_CYCLES`, 1024: continuous debounced-high cycles that declare a stuck loop (used only with `SENSOR_STUCK_DETECT_EN`).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `raw_a` in 1: asynchronous loop detector, street A (1 = vehicle over loop).
- `raw_b` in 1: asynchronous loop detector, street B.
- `la` in 2: street A light from controller (00 green, 01 yellow, 10 red, 11 treated as not green).
- `lb` in 2: street B light from controller, same encoding.
- `TA` out 1: registered traffic request, street A.
- `TB` out 1: registered traffic request, street B.
- `fault_a` out 1: stuck-loop flag, street A (sticky).
- `fault_b` out 1: stuck-loop flag, street B (sticky).

## Operation
Channels A and B are identical and independent; channel A is described below.

- **Synchroniser:** two flops `raw_a` → `s1` → `s2`; both reset to 0.
- **Debouncer:**
  - Debounced level `db` resets to 0.
  - The counter increments each cycle `s2 != db` and clears whenever `s2 == db`.
  - On the edge where the counter would reach `DEB_CYCLES`, `db` toggles and the counter clears.
- **Arrival:** a `db` 0→1 transition is one vehicle. `db` 1→0 has no queue effect.
- **Queue `q`** (`CNT_W` bits, reset 0):
  - +1 on arrival, saturating at max.
  - −1 on departure tick, floored at 0.
  - Arrival and departure in the same cycle leave `q` unchanged.
- **Departure timer:**
  - Counts while `la == 00` and `q != 0`; cleared otherwise.
  - On reaching `DEPART_CYCLES` it emits one departure tick and clears.
  - Yellow and red never drain the queue.
- **Hold timer:**
  - Loaded with `HOLD_CYCLES` on arrival.
  - Otherwise decrements toward 0 and stops at 0.
- **Request:** `TA <= db | (q != 0) | (hold != 0) | fault_a`.

## Timing
- **Reset values:** `TA`, `TB`, `fault_a`, `fault_b` = 0. All synchronisers, debouncers, queues and timers = 0.
- **Rise latency:** with `raw_a` stable high before edge 1, `db` rises at edge 2+`DEB_CYCLES` and `TA` rises at edge `DEB_CYCLES`+3 (7 with defaults). `q` and the hold timer update on that same edge.
- **Filtering:** a `raw_a` pulse shorter than `DEB_CYCLES` synchronised cycles produces no `db` change, no arrival and no `TA` change.
- **Fall:** `TA` falls on the edge after `db`, `q`, hold and fault are all 0.
- **Independence of `la`:** `la` affects only the departure timer. A change of `la` takes effect on the next edge.
- **Mid-operation reset:** `rst` asserted in any cycle clears all state on that edge; queued vehicles are discarded. `TA`/`TB` are 0 the cycle after.
- **Street independence:** simultaneous arrivals on A and B are both counted.

## Configuration
- **`SENSOR_STUCK_DETECT_EN` defined:**
  - A per-channel counter runs while `db == 1` and clears when `db == 0`.
  - At `STUCK_CYCLES` it sets `fault_a`, which stays set until `rst`.
  - While `fault_a == 1`, `TA` is forced 1, so the controller fails safe by serving the street.
- **Not defined:** no stuck counters are built, `fault_a`/`fault_b` are tied 0, and `TA`/`TB` follow the request equation without the fault term.

## Test plan
- **Reset:** hold `rst` 3 cycles with `raw_a`=`raw_b`=1 → `TA`=`TB`=`fault_a`=`fault_b`=0 throughout and on the cycle after release.
- **Clean arrival:** `raw_a` high 10 cycles, `la`=10 → `TA` rises exactly 7 cycles after the first sampling edge, `q`=1, `TB` stays 0.
- **Glitch:** `raw_b` high 3 cycles → `TB` never asserts and `q` stays 0.
- **Drain:** 3 arrivals on A with `la`=10, then `la`=00 held → `q` goes 3→2→1→0 at 8-cycle intervals. `TA` falls one cycle after `q`=0 (hold already expired). Switching `la` to 01 mid-drain freezes `q`.
- **Saturation and simultaneous events:** 20 arrivals with `la`=10 → `q`=15. An arrival on the same cycle as a departure tick leaves `q` unchanged.
- **Stuck loop:** `raw_b` held high 1100 cycles, then low.
  - With `SENSOR_STUCK_DETECT_EN`: `fault_b`=1 after 1024 debounced-high cycles; `TB` stays 1 after release until `rst`.
  - Without it: `fault_b`=0 and `TB` falls once the queue and hold are clear.
